instr_encoder: RTL

Sequential MIPS-subset instruction encoder and instruction-memory loader: the inverse of the main control decoder. It accepts one symbolic instruction per handshake (operation code plus register and immediate fields), packs it into a 32-bit word using the core's opcode/funct map, and writes it to instruction memory at an auto-incrementing word address. It sits between the test/boot program source and the instruction-memory write port, feeding exactly the opcodes the control decoder consumes.

---
 rtl/instr_encoder_pkg.sv | 65 ++++++
 rtl/instr_pack.sv | 86 ++++++++
 rtl/instr_encoder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the MIPS-subset instruction encoder: symbolic operation
// codes, the opcode/funct map used by the core's control decoder, and word-packing
// helpers.
package instr_encoder_pkg;

    // Symbolic operation presented on the request port; values 24-31 are illegal.
    typedef enum logic [4:0] {
        OpAdd  = 5'd0,  OpSub  = 5'd1,  OpAnd  = 5'd2,  OpOr   = 5'd3,
        OpSlt  = 5'd4,  OpNor  = 5'd5,  OpAddi = 5'd6,  OpSubi = 5'd7,
        OpAndi = 5'd8,  OpOri  = 5'd9,  OpSlti = 5'd10, OpLw   = 5'd11,
        OpLh   = 5'd12, OpLb   = 5'd13, OpSw   = 5'd14, OpSh   = 5'd15,
        OpSb   = 5'd16, OpLui  = 5'd17, OpBeq  = 5'd18, OpBne  = 5'd19,
        OpBgez = 5'd20, OpJ    = 5'd21, OpJal  = 5'd22, OpJr   = 5'd23
    } op_e;

    // Loader state: no word held, word waiting for memory, or memory exhausted.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StPend  = 2'd1,
        StFull  = 2'd2
    } enc_state_e;

    // Primary opcodes (bits 31:26).
    localparam logic [5:0] OpcRtype = 6'b000000;
    localparam logic [5:0] OpcBgez  = 6'b000001;
    localparam logic [5:0] OpcJ     = 6'b000010;
    localparam logic [5:0] OpcJal   = 6'b000011;
    localparam logic [5:0] OpcBeq   = 6'b000100;
    localparam logic [5:0] OpcBne   = 6'b000101;
    localparam logic [5:0] OpcAddi  = 6'b001000;
    localparam logic [5:0] OpcSlti  = 6'b001010;
    localparam logic [5:0] OpcAndi  = 6'b001100;
    localparam logic [5:0] OpcOri   = 6'b001101;
    localparam logic [5:0] OpcLui   = 6'b001111;
    localparam logic [5:0] OpcLb    = 6'b100000;
    localparam logic [5:0] OpcLh    = 6'b100001;
    localparam logic [5:0] OpcLw    = 6'b100011;
    localparam logic [5:0] OpcSb    = 6'b101000;
    localparam logic [5:0] OpcSh    = 6'b101001;
    localparam logic [5:0] OpcSw    = 6'b101011;
    localparam logic [5:0] OpcJr    = 6'b111110;
    localparam logic [5:0] OpcSubi  = 6'b111111;

    // R-type function codes (bits 5:0).
    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;
    localparam logic [5:0] FnNor = 6'b100111;

    // BGEZ shares the REGIMM opcode; the rt field selects the condition.
    localparam logic [4:0] BgezRt = 5'b00001;

    function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] fn);
        return {OpcRtype, rs, rt, rd, 5'b00000, fn};
    endfunction

    function automatic logic [31:0] pack_i(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: symbolic operation plus fields -> 32-bit instruction word,
// with illegal-op and immediate-range flags.
// Optional feature macro: ENC_CHECK_EN (immediate range checking).
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [4:0]  op_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [25:0] imm_i,
    output logic [31:0] word_o,
    output logic        illegal_o,
    output logic        range_err_o
);

    // How the upper immediate bits must look for the op to be representable.
    typedef enum logic [1:0] {ImmNone, ImmSigned, ImmZero} imm_kind_e;

    imm_kind_e   imm_kind;
    logic [15:0] imm16;

    assign imm16 = imm_i[15:0];

    // Select the encoding for the requested operation.
    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        imm_kind  = ImmNone;
        case (op_i)
            OpAdd:  word_o = pack_r(rs_i, rt_i, rd_i, FnAdd);
            OpSub:  word_o = pack_r(rs_i, rt_i, rd_i, FnSub);
            OpAnd:  word_o = pack_r(rs_i, rt_i, rd_i, FnAnd);
            OpOr:   word_o = pack_r(rs_i, rt_i, rd_i, FnOr);
            OpSlt:  word_o = pack_r(rs_i, rt_i, rd_i, FnSlt);
            OpNor:  word_o = pack_r(rs_i, rt_i, rd_i, FnNor);
            OpAddi: begin word_o = pack_i(OpcAddi, rs_i, rt_i, imm16); imm_kind = ImmSigned; end
            OpSubi: begin word_o = pack_i(OpcSubi, rs_i, rt_i, imm16); imm_kind = ImmSigned; end
            OpAndi: begin word_o = pack_i(OpcAndi, rs_i, rt_i, imm16); imm_kind = ImmZero;   end
            OpOri:  begin word_o = pack_i(OpcOri,  rs_i, rt_i, imm16); imm_kind = ImmZero;   end
            OpSlti: begin word_o = pack_i(OpcSlti, rs_i, rt_i, imm16); imm_kind = ImmSigned; end
            OpLw:   begin word_o = pack_i(OpcLw,   rs_i, rt_i, imm16); imm_kind = ImmSigned; end
            OpLh:   begin word_o = pack_i(OpcLh,   rs_i, rt_i, imm16); imm_kind = ImmSigned; end
            OpLb:   begin word_o = pack_i(OpcLb,   rs_i, rt_i, imm16); imm_kind = ImmSigned; end
            OpSw:   begin word_o = pack_i(OpcSw,   rs_i, rt_i, imm16); imm_kind = ImmSigned; end
            OpSh:   begin word_o = pack_i(OpcSh,   rs_i, rt_i, imm16); imm_kind = ImmSigned; end
            OpSb:   begin word_o = pack_i(OpcSb,   rs_i, rt_i, imm16); imm_kind = ImmSigned; end
            // LUI has no source register; rs is forced to zero.
            OpLui:  begin word_o = pack_i(OpcLui,  5'd0, rt_i, imm16); imm_kind = ImmZero;   end
            OpBeq:  begin word_o = pack_i(OpcBeq,  rs_i, rt_i, imm16); imm_kind = ImmSigned; end
            OpBne:  begin word_o = pack_i(OpcBne,  rs_i, rt_i, imm16); imm_kind = ImmSigned; end
            OpBgez: begin
                word_o   = pack_i(OpcBgez, rs_i, BgezRt, imm16);
                imm_kind = ImmSigned;
            end
            OpJ:    word_o = {OpcJ, imm_i};
            OpJal:  word_o = {OpcJal, imm_i};
            OpJr:   word_o = {OpcJr, rs_i, 21'b0};
            default: illegal_o = 1'b1;
        endcase
    end

`ifdef ENC_CHECK_EN
    logic sext_ok;
    logic zext_ok;

    assign sext_ok = (imm_i[25:16] == {10{imm_i[15]}});
    assign zext_ok = (imm_i[25:16] == 10'd0);

    // Flag immediates that would lose information when truncated to 16 bits.
    always_comb begin
        range_err_o = 1'b0;
        case (imm_kind)
            ImmSigned: range_err_o = !sext_ok;
            ImmZero:   range_err_o = !zext_ok;
            default:   range_err_o = 1'b0;
        endcase
    end
`else
    logic unused_imm_kind;

    assign unused_imm_kind = ^imm_kind;
    assign range_err_o     = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Sequential instruction encoder / instruction-memory loader. Accepts one symbolic
// instruction per handshake, packs it and writes it to consecutive word addresses.
// Optional feature macro: ENC_CHECK_EN (immediate range checking, sets err_range_o).
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [4:0]        in_op_i,
    input  logic [4:0]        in_rs_i,
    input  logic [4:0]        in_rt_i,
    input  logic [4:0]        in_rd_i,
    input  logic [25:0]       in_imm_i,
    output logic              imem_valid_o,
    input  logic              imem_ready_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              err_illegal_o,
    output logic              err_range_o
);

    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LastAddr = '1;

    enc_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_ill_q, err_ill_d;
    logic              err_rng_q, err_rng_d;

    logic [31:0] pack_word;
    logic        pack_illegal;
    logic        pack_range;
    logic        write_done;
    logic        last_pend;
    logic        accept;

    instr_pack u_pack (
        .op_i        (in_op_i),
        .rs_i        (in_rs_i),
        .rt_i        (in_rt_i),
        .rd_i        (in_rd_i),
        .imm_i       (in_imm_i),
        .word_o      (pack_word),
        .illegal_o   (pack_illegal),
        .range_err_o (pack_range)
    );

    assign write_done = (state_q == StPend) && imem_ready_i;
    // The final slot is pending: a word taken now would have nowhere to go, so hold off.
    assign last_pend  = (state_q == StPend) && (addr_q == LastAddr);
    assign in_ready_o = (state_q == StEmpty) ||
                        ((state_q == StPend) && imem_ready_i && !last_pend);
    assign accept     = in_valid_i && in_ready_o;

    // Next-state: retire the pending write, then latch a newly accepted word.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        count_d   = count_q;
        err_ill_d = err_ill_q;
        err_rng_d = err_rng_q;
        if (clear_i) begin
            state_d   = StEmpty;
            addr_d    = BaseAddr;
            wdata_d   = '0;
            count_d   = '0;
            err_ill_d = 1'b0;
            err_rng_d = 1'b0;
        end else begin
            if (write_done) begin
                count_d = count_q + 1'b1;
                if (addr_q == LastAddr) begin
                    state_d = StFull;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = StEmpty;
                end
            end
            if (accept) begin
                if (pack_illegal) begin
                    err_ill_d = 1'b1;
                end else if (pack_range) begin
                    err_rng_d = 1'b1;
                end else begin
                    wdata_d = pack_word;
                    state_d = StPend;
                end
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StEmpty;
            addr_q    <= BaseAddr;
            wdata_q   <= '0;
            count_q   <= '0;
            err_ill_q <= 1'b0;
            err_rng_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            count_q   <= count_d;
            err_ill_q <= err_ill_d;
            err_rng_q <= err_rng_d;
        end
    end

    assign imem_valid_o  = (state_q == StPend);
    assign imem_addr_o   = addr_q;
    assign imem_wdata_o  = wdata_q;
    assign count_o       = count_q;
    assign full_o        = (state_q == StFull);
    assign err_illegal_o = err_ill_q;
    assign err_range_o   = err_rng_q;

endmodule
